uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side frame buffer that sits directly downstream of the UART receiver.
- Captures each completed frame on the receiver's done pulse, together with its parity-check result.
- Holds frames in a first-word-fall-through FIFO for a valid/ready consumer.
- Tracks overruns and parity errors in sticky flags and saturating counters, so software or a bus wrapper can drain and diagnose the link.

Parameters:
- DATA_WIDTH, 8: frame payload width; must match the receiver.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- CNT_WIDTH, 8: width of the error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- rx_data  in  DATA_WIDTH  payload from receiver; sampled only when rx_done=1.
- rx_valid  in  1  parity-check result from receiver (1 = good); sampled only when rx_done=1.
- rx_done  in  1  one-cycle frame-complete strobe from receiver.
- drop_bad  in  1  1 = discard frames with rx_valid=0 instead of storing them.
- flush  in  1  synchronous FIFO clear.
- clr_err  in  1  clears overrun flag and both counters.
- m_data  out  DATA_WIDTH  head-of-FIFO payload.
- m_perr  out  1  head entry had a parity error.
- m_valid  out  1  head entry available.
- m_ready  in  1  consumer accepts head.
- level  out  $clog2(DEPTH)+1  number of stored entries.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overrun  out  1  sticky; a frame was lost because the FIFO was full.
- perr_cnt  out  CNT_WIDTH  saturating count of received frames with rx_valid=0.
- ovr_cnt  out  CNT_WIDTH  saturating count of frames lost to overrun.

Behaviour:
- Reset (rst=0 at a clock edge): pointers, level, overrun, perr_cnt and ovr_cnt all 0; empty=1, full=0, m_valid=0. Storage is not reset.
- Storage: DEPTH x (DATA_WIDTH+1) entries of {perr, data}, with perr = ~rx_valid.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits and wrap naturally.
  - level = wr_ptr - rd_ptr.
  - full when the MSBs differ and the remaining bits are equal.
- Output (FWFT):
  - m_valid = ~empty.
  - m_data/m_perr = entry at rd_ptr, combinational from storage.
  - m_data=0 and m_perr=0 whenever empty.
- pop = m_valid & m_ready. rd_ptr advances at the next edge; the new head is visible the same cycle rd_ptr updates.
- Frame event = rx_done=1. It is classified as:
  - bad: rx_valid=0.
  - discard: bad & drop_bad.
  - push: ~discard & (~full | pop).
  - lost: ~discard & full & ~pop.
- Push writes {~rx_valid, rx_data} at wr_ptr; wr_ptr increments. Latency is one cycle: an rx_done at cycle N into an empty FIFO gives m_valid=1 at N+1.
- Full with simultaneous push and pop: both occur; level stays DEPTH; full stays 1.
- Empty with simultaneous push and pop: pop is impossible because m_valid=0; push proceeds.
- Lost frame: data discarded; overrun set at the next edge; ovr_cnt += 1, saturating at all-ones.
- Parity errors: perr_cnt += 1 on every bad frame event (stored, discarded or lost), saturating at all-ones.
- flush=1: next edge sets rd_ptr=wr_ptr=0. It overrides any push or pop in the same cycle; a frame arriving that cycle is neither stored nor counted as lost. perr_cnt still counts a bad frame. overrun and the counters are unaffected.
- clr_err=1: next edge clears overrun, perr_cnt and ovr_cnt. If an overrun or parity event occurs in the same cycle, the event wins: the flag is set or the counter loads 1.
- Precedence within a cycle: rst > flush > push/pop. Counter updates are independent of flush except as stated above.
- rx_data and rx_valid are ignored when rx_done=0.
- Back-to-back rx_done pulses on consecutive cycles must be handled, even though the receiver never produces them.

Test Plan:
- Single frame, good parity: rx_done with rx_data=0xA5, rx_valid=1, m_ready=0 -> next cycle m_valid=1, m_data=0xA5, m_perr=0, level=1. Then m_ready=1 for one cycle -> empty=1, m_data=0.
- Fill and overrun: 17 frames (0x00..0x10) with DEPTH=16 and m_ready=0 -> full=1, level=16, overrun=1, ovr_cnt=1. Draining returns 0x00..0x0F in order; 0x10 is absent.
- Full, push and pop in the same cycle: rx_done=0x55 with m_ready=1 -> level stays 16, overrun stays 0. The last entry popped after draining is 0x55.
- Parity handling: bad frame 0x3C with drop_bad=0 -> stored with m_perr=1, perr_cnt=1. Bad frame with drop_bad=1 -> not stored, level unchanged, perr_cnt=2.
- Flush and clear collisions:
  - flush with 5 entries and a simultaneous rx_done -> level=0 next cycle, ovr_cnt unchanged.
  - clr_err coinciding with an overrun event -> overrun=1, ovr_cnt=1.
- Reset mid-operation: rst=0 with level=7 and overrun=1 -> next cycle level=0, empty=1, m_valid=0, overrun=0, both counters 0. Normal operation resumes once rst=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side frame buffer: captures UART frames with their parity status into a
// first-word-fall-through FIFO and keeps sticky overrun / saturating error statistics.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_done,
  input  logic                    drop_bad,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_perr,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic                    overrun,
  output logic [CNT_WIDTH-1:0]    perr_cnt,
  output logic [CNT_WIDTH-1:0]    ovr_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 1;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0] perr_cnt_q, perr_cnt_d;
  logic [CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;

  logic [EW-1:0] head;
  logic          pop, bad, keep, push, lost;

  // A counter event in the same cycle as a clear leaves the counter at one.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc, input logic clr);
    if (inc) begin
      if (clr) return CNT_WIDTH'(1);
      return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    end
    return clr ? '0 : cnt;
  endfunction

  // Status and head-of-queue view, all derived from the pointers.
  always_comb begin
    level   = wr_ptr_q - rd_ptr_q;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    m_valid = ~empty;
    head    = mem_q[rd_ptr_q[AW-1:0]];
    m_data  = empty ? '0 : head[DATA_WIDTH-1:0];
    m_perr  = ~empty & head[DATA_WIDTH];
  end

  // Frame classification; a flush suppresses both storing and overrun accounting.
  always_comb begin
    pop  = m_valid & m_ready;
    bad  = rx_done & ~rx_valid;
    keep = rx_done & ~(bad & drop_bad) & ~flush;
    push = keep & (~full | pop);
    lost = keep & full & ~pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    end
    overrun_d  = (overrun_q & ~clr_err) | lost;
    perr_cnt_d = cnt_next(perr_cnt_q, bad, clr_err);
    ovr_cnt_d  = cnt_next(ovr_cnt_q, lost, clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overrun_q  <= 1'b0;
      perr_cnt_q <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overrun_q  <= overrun_d;
      perr_cnt_q <= perr_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  // Storage is deliberately left unreset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q[AW-1:0]] <= {~rx_valid, rx_data};
  end

  assign overrun  = overrun_q;
  assign perr_cnt = perr_cnt_q;
  assign ovr_cnt  = ovr_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, rx_valid, rx_done, drop_bad, flush, clr_err, m_ready;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] m_data;
  logic          m_perr, m_valid, full, empty, overrun;
  logic [LW-1:0] level;
  logic [CW-1:0] perr_cnt, ovr_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW:0] mq[$];
  int          m_pcnt, m_ocnt;
  bit          m_ovr;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_done(rx_done),
    .drop_bad(drop_bad), .flush(flush), .clr_err(clr_err), .m_data(m_data),
    .m_perr(m_perr), .m_valid(m_valid), .m_ready(m_ready), .level(level), .full(full),
    .empty(empty), .overrun(overrun), .perr_cnt(perr_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int cnt_upd(input int c, input bit ev, input bit clr);
    if (clr) return ev ? 1 : 0;
    if (ev) return (c < CMAX) ? c + 1 : CMAX;
    return c;
  endfunction

  // Reference model: a queue of {perr, data} plus plain integer statistics.
  task automatic model_step();
    bit pop, bad, lost, was_full;
    if (!rst) begin
      mq.delete();
      m_pcnt = 0;
      m_ocnt = 0;
      m_ovr  = 0;
    end else begin
      bad  = rx_done && !rx_valid;
      pop  = (mq.size() != 0) && m_ready;
      lost = 0;
      if (flush) mq.delete();
      else begin
        was_full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (rx_done && !(bad && drop_bad)) begin
          if (!was_full || pop) mq.push_back({!rx_valid, rx_data});
          else lost = 1;
        end
      end
      m_ovr  = clr_err ? lost : (m_ovr || lost);
      m_pcnt = cnt_upd(m_pcnt, bad, clr_err);
      m_ocnt = cnt_upd(m_ocnt, lost, clr_err);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("model m_valid", int'(m_valid), (sz != 0) ? 1 : 0);
    chk("model level", int'(level), sz);
    chk("model full", int'(full), (sz == DEPTH) ? 1 : 0);
    chk("model empty", int'(empty), (sz == 0) ? 1 : 0);
    chk("model m_data", int'(m_data), (sz != 0) ? int'(mq[0][DW-1:0]) : 0);
    chk("model m_perr", int'(m_perr), (sz != 0) ? int'(mq[0][DW]) : 0);
    chk("model overrun", int'(overrun), int'(m_ovr));
    chk("model perr_cnt", int'(perr_cnt), m_pcnt);
    chk("model ovr_cnt", int'(ovr_cnt), m_ocnt);
  endtask

  // Drive one cycle of inputs after the falling edge; sample 1 time unit past the rising edge.
  task automatic step(input int r, input int d, input int data, input int v, input int dr,
                      input int f, input int c, input int rd);
    @(negedge clk);
    rst = 1'(r); rx_done = 1'(d); rx_data = DW'(data); rx_valid = 1'(v);
    drop_bad = 1'(dr); flush = 1'(f); clr_err = 1'(c); m_ready = 1'(rd);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push_good(input int data);
    step(1, 1, data, 1, 0, 0, 0, 0);
  endtask

  typedef struct {
    int r, d, data, v, dr, f, c, rd;
    int e_level, e_valid, e_data, e_perr, e_ovr, e_pcnt, e_ocnt;
  } vec_t;

  vec_t vec[15];
  int   exp_d;
  int   rdy;

  initial begin
    rst = 1'b0; rx_done = 1'b0; rx_data = '0; rx_valid = 1'b0;
    drop_bad = 1'b0; flush = 1'b0; clr_err = 1'b0; m_ready = 1'b0;

    //           r d data  v dr f c rd   lvl val data perr ovr pc oc
    vec[0]  = '{0, 0, 0,    0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 0};
    vec[1]  = '{1, 1, 'hA5, 1, 0, 0, 0, 0,   1, 1, 'hA5, 0, 0, 0, 0};
    vec[2]  = '{1, 0, 0,    0, 0, 0, 0, 1,   0, 0, 0,    0, 0, 0, 0};
    vec[3]  = '{1, 1, 'h3C, 0, 0, 0, 0, 0,   1, 1, 'h3C, 1, 0, 1, 0};
    vec[4]  = '{1, 1, 'h77, 0, 1, 0, 0, 0,   1, 1, 'h3C, 1, 0, 2, 0};
    vec[5]  = '{1, 0, 0,    0, 0, 0, 0, 1,   0, 0, 0,    0, 0, 2, 0};
    vec[6]  = '{1, 0, 0,    0, 0, 0, 1, 0,   0, 0, 0,    0, 0, 0, 0};
    vec[7]  = '{1, 1, 'h11, 1, 0, 1, 0, 0,   0, 0, 0,    0, 0, 0, 0};
    vec[8]  = '{1, 1, 'h22, 0, 0, 1, 0, 0,   0, 0, 0,    0, 0, 1, 0};
    vec[9]  = '{1, 1, 'h33, 0, 1, 0, 1, 0,   0, 0, 0,    0, 0, 1, 0};
    vec[10] = '{1, 1, 'h44, 1, 0, 0, 1, 0,   1, 1, 'h44, 0, 0, 0, 0};
    vec[11] = '{1, 1, 'h55, 1, 0, 0, 0, 1,   1, 1, 'h55, 0, 0, 0, 0};
    vec[12] = '{1, 0, 0,    0, 0, 0, 0, 1,   0, 0, 0,    0, 0, 0, 0};
    vec[13] = '{1, 1, 'h66, 1, 0, 0, 0, 1,   1, 1, 'h66, 0, 0, 0, 0};
    vec[14] = '{1, 1, 'h77, 1, 0, 1, 0, 1,   0, 0, 0,    0, 0, 0, 0};

    foreach (vec[i]) begin
      step(vec[i].r, vec[i].d, vec[i].data, vec[i].v, vec[i].dr, vec[i].f, vec[i].c, vec[i].rd);
      chk($sformatf("vec%0d level", i), int'(level), vec[i].e_level);
      chk($sformatf("vec%0d m_valid", i), int'(m_valid), vec[i].e_valid);
      chk($sformatf("vec%0d empty", i), int'(empty), 1 - vec[i].e_valid);
      chk($sformatf("vec%0d m_data", i), int'(m_data), vec[i].e_data);
      chk($sformatf("vec%0d m_perr", i), int'(m_perr), vec[i].e_perr);
      chk($sformatf("vec%0d overrun", i), int'(overrun), vec[i].e_ovr);
      chk($sformatf("vec%0d perr_cnt", i), int'(perr_cnt), vec[i].e_pcnt);
      chk($sformatf("vec%0d ovr_cnt", i), int'(ovr_cnt), vec[i].e_ocnt);
    end

    // Fill past capacity: the 17th frame is lost.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= DEPTH; i++) push_good(i);
    chk("fill full", int'(full), 1);
    chk("fill level", int'(level), DEPTH);
    chk("fill overrun", int'(overrun), 1);
    chk("fill ovr_cnt", int'(ovr_cnt), 1);

    // Push and pop together while full.
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("clr overrun", int'(overrun), 0);
    chk("pp head", int'(m_data), 0);
    step(1, 1, 'h55, 1, 0, 0, 0, 1);
    chk("pp level", int'(level), DEPTH);
    chk("pp full", int'(full), 1);
    chk("pp overrun", int'(overrun), 0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_d = (i < DEPTH - 1) ? i + 1 : 'h55;
      chk($sformatf("drain%0d", i), int'(m_data), exp_d);
      step(1, 0, 0, 0, 0, 0, 0, 1);
    end
    chk("drain empty", int'(empty), 1);

    // Flush with entries present and a colliding frame.
    for (int i = 0; i < 5; i++) push_good('h90 + i);
    chk("pre-flush level", int'(level), 5);
    step(1, 1, 'h99, 1, 0, 1, 0, 0);
    chk("flush level", int'(level), 0);
    chk("flush empty", int'(empty), 1);
    chk("flush ovr_cnt", int'(ovr_cnt), 0);

    // Clear colliding with an overrun event.
    for (int i = 0; i < DEPTH; i++) push_good('h20 + i);
    push_good('hEE);
    chk("lost ovr_cnt", int'(ovr_cnt), 1);
    step(1, 1, 'hEF, 1, 0, 0, 1, 0);
    chk("clr-vs-ovr overrun", int'(overrun), 1);
    chk("clr-vs-ovr ovr_cnt", int'(ovr_cnt), 1);

    // Reset in the middle of operation with level 7 and overrun set.
    for (int i = 0; i < DEPTH - 7; i++) step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("pre-rst level", int'(level), 7);
    chk("pre-rst overrun", int'(overrun), 1);
    step(0, 1, 'h12, 0, 0, 0, 0, 1);
    chk("rst level", int'(level), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst m_valid", int'(m_valid), 0);
    chk("rst overrun", int'(overrun), 0);
    chk("rst perr_cnt", int'(perr_cnt), 0);
    chk("rst ovr_cnt", int'(ovr_cnt), 0);
    push_good('hC3);
    chk("post-rst level", int'(level), 1);
    chk("post-rst m_data", int'(m_data), 'hC3);

    // Saturation: every frame is both bad and lost once full.
    for (int i = 0; i < DEPTH - 1; i++) push_good(i);
    for (int i = 0; i < CMAX + 45; i++) step(1, 1, i & 'hFF, 0, 0, 0, 0, 0);
    chk("sat perr_cnt", int'(perr_cnt), CMAX);
    chk("sat ovr_cnt", int'(ovr_cnt), CMAX);
    chk("sat level", int'(level), DEPTH);
    step(1, 1, 'hAB, 0, 0, 0, 1, 0);
    chk("sat clr perr_cnt", int'(perr_cnt), 1);
    chk("sat clr ovr_cnt", int'(ovr_cnt), 1);
    check_model();

    // Randomized traffic with alternating drain pressure.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (((cyc / 250) % 2) != 0) rdy = ($urandom_range(0, 9) < 8) ? 1 : 0;
      else rdy = ($urandom_range(0, 9) < 2) ? 1 : 0;
      step(($urandom_range(0, 199) != 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0) ? 1 : 0,
           ($urandom_range(0, 49) == 0) ? 1 : 0,
           rdy);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
